// File: rtl/xor_checksum_pkg.sv
// rtl/xor_checksum_pkg.sv - shared types and helpers for the XOR checksum engine
package xor_checksum_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MAX_W = 64;

  // Width-generic rotate-left by one: callers zero-extend to MAX_W and pass the live width.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] word, input int width);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    return ((word << 1) | (word >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/xor_n.sv
// rtl/xor_n.sv - WIDTH-bit XOR built from per-bit NAND-composite XOR cells
module xor_bit (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n_ab;
  logic n_a;
  logic n_b;

  assign n_ab = ~(a & b);
  assign n_a  = ~(a & n_ab);
  assign n_b  = ~(b & n_ab);
  assign y    = ~(n_a & n_b);
endmodule

module xor_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor_bit u_bit (
      .a(a[i]),
      .b(b[i]),
      .y(y[i])
    );
  end
endmodule

// File: rtl/xor_checksum.sv
// rtl/xor_checksum.sv - streaming XOR/rotate-XOR packet checksum with beat count
module xor_checksum
  import xor_checksum_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 8,
  parameter int ROTATE = 0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_src;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf;
  logic             ovf_next;
  logic             cnt_full;
  logic             accept;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  // A beat offered alongside clear is dropped even though in_ready is high.
  assign accept    = in_valid && in_ready && !clear;

  assign acc_src  = (ROTATE != 0) ? WIDTH'(rotl1(MAX_W'(acc), WIDTH)) : acc;
  assign cnt_full = (cnt == CNT_MAX);
  assign cnt_next = cnt_full ? cnt : cnt + CNT_W'(1);
  assign ovf_next = ovf | cnt_full;

  xor_n #(.WIDTH(WIDTH)) u_fold (
    .a(acc_src),
    .b(in_data),
    .y(acc_next)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (accept && in_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
    if (clear) state_next = ACC;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_sum      <= acc_next;
        out_count    <= cnt_next;
        out_overflow <= ovf_next;
        acc          <= '0;
        cnt          <= '0;
        ovf          <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: doc/xor_checksum.md
Name: xor_checksum

Overview:
- Streaming XOR checksum engine: folds a packet of WIDTH-bit words, delimited by in_last, into one WIDTH-bit signature.
- Reports the signature together with the packet's beat count.
- Parametrised sequential successor to the single-bit XOR gate: adds width, an optional rotate-XOR mode, beat counting and valid/ready handshakes.
- Used by Hack-side debug and self-test logic to sign ROM/RAM streams.

Parameters:
- WIDTH, 16, data and checksum width in bits (Hack word).
- CNT_W, 8, beat counter width; count saturates at 2^CNT_W-1.
- ROTATE, 0, 0 = plain XOR fold; 1 = rotate accumulator left by 1, then XOR.

Ports:
- clk_sys  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort/flush, highest synchronous priority.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine accepts a word this cycle.
- in_data  in  WIDTH  input word.
- in_last  in  1  word is the final beat of the packet.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  packet checksum.
- out_count  out  CNT_W  beats in packet, including the last beat.
- out_overflow  out  1  packet exceeded 2^CNT_W-1 beats.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=ACC; acc=0; cnt=0; ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready=1 from the first clock after release.
- FSM states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat acceptance in ACC: a beat is accepted when in_valid&&in_ready.
  - acc_next = (ROTATE ? rotl(acc,1) : acc) ^ in_data.
  - cnt_next = saturating cnt+1.
  - ovf is set if a beat is accepted while cnt==2^CNT_W-1.
- Last beat (accepted beat with in_last=1):
  - out_sum <= acc_next; out_count <= cnt_next; out_overflow <= ovf_next.
  - acc, cnt and ovf clear to 0.
  - state -> HOLD.
  - out_valid is high on the following cycle: 1-cycle latency from last beat to result.
- HOLD:
  - out_sum, out_count and out_overflow are stable.
  - On out_ready=1: out_valid drops next cycle and state -> ACC.
  - No input is accepted in the same cycle as the handoff; in_ready returns the cycle after out_ready is seen.
- in_valid=0 in ACC: no state change. Gaps inside a packet are legal.
- clear=1:
  - Next edge: acc=0, cnt=0, ovf=0, state=ACC, out_valid=0; out_* data registers hold their values.
  - Any beat presented that cycle is discarded, even though in_ready=1.
  - Overrides in_last and out_ready.
- reset_n asserted mid-packet or in HOLD: the partial packet is lost; the next packet starts from acc=0.
- Out-of-range values: none. The XOR fold is width-exact, with no carries.

Decomposition:
- Package xor_checksum_pkg:
  - state enum {ACC, HOLD}.
  - function rotl1(word) for the WIDTH-generic rotate.
- Sub-module xor_n: WIDTH-parametrised bitwise XOR. Its generate loop instantiates the existing 1-bit XOR composite per bit, so the gate-level lineage is kept. xor_checksum instantiates one xor_n for the fold.

Test Plan:
- ROTATE=0: beats 0x1234, 0x00FF(last) -> out_valid one cycle after the last beat, out_sum=0x12CB, out_count=2, out_overflow=0.
- Single-beat packet 0xA5A5(last) -> out_sum=0xA5A5, out_count=1. The next packet 0x0001(last) gives 0x0001, with no carry-over from the previous packet.
- Backpressure: after a packet completes, hold out_ready=0 for 5 cycles -> out_valid=1, in_ready=0 and out_sum stable throughout. Assert out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- ROTATE=1: beats 0x8001, 0x0001(last) -> out_sum=0x0002, out_count=2.
- CNT_W=2: 5-beat packet of 0x0001 each -> out_sum=0x0001, out_count=3, out_overflow=1.
- Abort paths:
  - Drop reset_n after 2 beats (0xFFFF, 0x0F00) -> out_valid=0 immediately. Then packet 0x0F0F(last) -> out_sum=0x0F0F, out_count=1.
  - Repeat with clear instead of reset -> same result.
  - clear together with a last beat -> no result; out_valid stays 0.
